tdc_tap_decoder: RTL

Consumer end of the CARRY4 delay line: samples the NUM-bit thermometer tap vector, detects each new hit, bubble-corrects and encodes the tap pattern into a fine code, and pairs it with a free-running coarse count. It outputs one {coarse, fine} timestamp per hit over a valid/ready handshake. It sits between the delay-chain instance and the timestamp FIFO/readout logic.

---
 rtl/tdc_pkg.sv | 35 +++
 rtl/tdc_tap_decoder_if.sv | 38 +++
 rtl/tdc_thermo_encoder.sv | 55 +++++
 rtl/tdc_tap_decoder.sv | 133 +++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// ============================================================================
// Module      : tdc_pkg
// Description : Shared defaults, arm FSM state encoding and timestamp record
//               for the TDC tap decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tdc_pkg;

  localparam int DEF_NUM      = 12;
  localparam int DEF_COARSE_W = 16;
  localparam int DEF_DROP_W   = 8;

  // Fine code must be able to represent every count from 0 to num inclusive.
  function automatic int fine_w(input int num);
    return $clog2(num + 1);
  endfunction

  localparam int DEF_FINE_W = fine_w(DEF_NUM);

  typedef enum logic [0:0] {
    ARMED    = 1'b0,
    WAIT_LOW = 1'b1
  } arm_state_t;

  typedef struct packed {
    logic [DEF_COARSE_W-1:0] coarse;
    logic [DEF_FINE_W-1:0]   fine;
    logic                    sat;
  } ts_t;

endpackage

`default_nettype wire

// File: rtl/tdc_tap_decoder_if.sv
// ============================================================================
// Module      : tdc_tap_decoder_if
// Description : Timestamp valid/ready channel from the tap decoder to the
//               readout side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tdc_tap_decoder_if #(
  parameter int COARSE_W = 16,
  parameter int FINE_W   = 4
) ();

  logic                ts_valid;
  logic                ts_ready;
  logic [COARSE_W-1:0] ts_coarse;
  logic [FINE_W-1:0]   ts_fine;
  logic                ts_sat;

  modport master (
    output ts_valid,
    output ts_coarse,
    output ts_fine,
    output ts_sat,
    input  ts_ready
  );

  modport slave (
    input  ts_valid,
    input  ts_coarse,
    input  ts_fine,
    input  ts_sat,
    output ts_ready
  );

endinterface

`default_nettype wire

// File: rtl/tdc_thermo_encoder.sv
// ============================================================================
// Module      : tdc_thermo_encoder
// Description : One registered stage: three-tap majority bubble correction
//               of the thermometer vector followed by a population count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tdc_thermo_encoder #(
  parameter int NUM    = 12,
  parameter int FINE_W = $clog2(NUM + 1)
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic [NUM-1:0]    taps,
  output logic      [FINE_W-1:0] fine,
  output logic                   sat
);

  // Tap -1 is treated as a one and tap NUM as a zero so the ends of the
  // chain vote like an ideal thermometer code.
  logic [NUM+1:0]    w_ext;
  logic [NUM-1:0]    w_corr;
  logic [FINE_W-1:0] w_count;

  assign w_ext = {1'b0, taps, 1'b1};

  for (genvar gi = 0; gi < NUM; gi++) begin : g_maj
    assign w_corr[gi] = (w_ext[gi]   & w_ext[gi+1]) |
                        (w_ext[gi]   & w_ext[gi+2]) |
                        (w_ext[gi+1] & w_ext[gi+2]);
  end

  // Population count of the corrected vector.
  always_comb begin
    w_count = '0;
    for (int i = 0; i < NUM; i++) begin
      w_count = w_count + FINE_W'(w_corr[i]);
    end
  end

  // Register the fine code and the saturation flag together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fine <= '0;
      sat  <= 1'b0;
    end else begin
      fine <= w_count;
      sat  <= w_corr[NUM-1];
    end
  end

endmodule

`default_nettype wire

// File: rtl/tdc_tap_decoder.sv
// ============================================================================
// Module      : tdc_tap_decoder
// Description : Samples the delay-line taps, detects new hits, encodes the
//               fine code and emits {coarse, fine, sat} timestamps over a
//               valid/ready channel with a saturating drop counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tdc_tap_decoder
  import tdc_pkg::*;
#(
  parameter int NUM      = DEF_NUM,
  parameter int COARSE_W = DEF_COARSE_W,
  parameter int FINE_W   = fine_w(NUM),
  parameter int DROP_W   = DEF_DROP_W
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic [NUM-1:0]    taps_in,
  input  wire logic              enable,
  tdc_tap_decoder_if.master      ts,
  output logic      [DROP_W-1:0] drop_count
);

  logic [NUM-1:0]      r_tap1;
  logic [NUM-1:0]      r_tap2;
  arm_state_t          r_state;
  logic                r_evt;
  logic [COARSE_W-1:0] r_cnt;
  logic [COARSE_W-1:0] r_cnt_d;
  logic [COARSE_W-1:0] r_coarse;
  logic [FINE_W-1:0]   w_fine;
  logic                w_sat;
  logic                r_valid;
  logic [COARSE_W-1:0] r_ts_coarse;
  logic [FINE_W-1:0]   r_ts_fine;
  logic                r_ts_sat;
  logic [DROP_W-1:0]   r_drop;
  logic                w_load;

  // Two-flop capture of the asynchronous tap vector.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tap1 <= '0;
      r_tap2 <= '0;
    end else begin
      r_tap1 <= taps_in;
      r_tap2 <= r_tap1;
    end
  end

  // Arm FSM: one event per rising hit, re-armed only once tap 0 reads low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ARMED;
      r_evt   <= 1'b0;
    end else begin
      r_evt <= 1'b0;
      case (r_state)
        ARMED: begin
          if (enable && r_tap2[0]) begin
            r_evt   <= 1'b1;
            r_state <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (!r_tap2[0]) r_state <= ARMED;
        end
        default: r_state <= ARMED;
      endcase
    end
  end

  // Free-running coarse count; r_cnt_d holds the count seen while the
  // sample was in the first capture flop, r_coarse aligns it with the event.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_cnt_d  <= '0;
      r_coarse <= '0;
    end else begin
      r_cnt    <= r_cnt + COARSE_W'(1);
      r_cnt_d  <= r_cnt;
      r_coarse <= r_cnt_d;
    end
  end

  tdc_thermo_encoder #(
    .NUM    (NUM),
    .FINE_W (FINE_W)
  ) u_enc (
    .clk  (clk),
    .rst  (rst),
    .taps (r_tap2),
    .fine (w_fine),
    .sat  (w_sat)
  );

  assign w_load = r_evt && (!r_valid || ts.ts_ready);

  // Output holding register and drop counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid     <= 1'b0;
      r_ts_coarse <= '0;
      r_ts_fine   <= '0;
      r_ts_sat    <= 1'b0;
      r_drop      <= '0;
    end else begin
      if (w_load) begin
        r_valid     <= 1'b1;
        r_ts_coarse <= r_coarse;
        r_ts_fine   <= w_fine;
        r_ts_sat    <= w_sat;
      end else if (ts.ts_ready) begin
        r_valid <= 1'b0;
      end
      if (r_evt && r_valid && !ts.ts_ready && (r_drop != '1)) begin
        r_drop <= r_drop + DROP_W'(1);
      end
    end
  end

  assign ts.ts_valid  = r_valid;
  assign ts.ts_coarse = r_ts_coarse;
  assign ts.ts_fine   = r_ts_fine;
  assign ts.ts_sat    = r_ts_sat;
  assign drop_count   = r_drop;

endmodule

`default_nettype wire
